seq_mult_ctrl: RTL and testbench

- Sequential shift-add multiplier controller: computes an unsigned WIDTH x WIDTH product over WIDTH cycles.
- Time-shares one WIDTH-bit ripple-carry adder instance (parametric_RCA, ci tied 0).
- Sits between a requester and a consumer, with valid/ready handshakes on both sides.
- Trades area for latency versus a combinational array multiplier.

---
 rtl/seq_mult_pkg.sv | 18 +
 rtl/parametric_RCA.sv | 23 ++
 rtl/seq_mult_ctrl.sv | 122 ++++++++++++
 tb/tb_seq_mult_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared state encoding and sizing helper for the sequential shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bits needed to hold 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/parametric_RCA.sv
// Ripple-carry adder, SIZE bits wide, with carry-in and carry-out.
module parametric_RCA #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            ci,
  output logic [SIZE-1:0] s,
  output logic            co
);

  always_comb begin
    logic carry;
    carry = ci;
    s     = '0;
    for (int i = 0; i < SIZE; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential WIDTH x WIDTH shift-add multiplier with valid/ready on both sides.
// Define SEQ_MULT_SIGNED_EN for two's complement operands (sign-magnitude around the unsigned core).
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_t           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] addend, sum;
  logic             carry;
  logic [PW-1:0]    acc_shift, acc_fin;
  logic [WIDTH-1:0] a_ld, b_ld;

  assign addend = acc_q[0] ? mcand_q : '0;

  parametric_RCA #(.SIZE(WIDTH)) u_rca (
    .a  (acc_q[PW-1:WIDTH]),
    .b  (addend),
    .ci (1'b0),
    .s  (sum),
    .co (carry)
  );

  // Carry-out of the upper half becomes the new MSB as the accumulator shifts right.
  assign acc_shift = {carry, sum, acc_q[WIDTH-1:1]};

`ifdef SEQ_MULT_SIGNED_EN
  logic neg_q, neg_d;

  assign a_ld    = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign b_ld    = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  assign acc_fin = neg_q ? (~acc_shift + PW'(1)) : acc_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= neg_d;
  end
`else
  assign a_ld    = a;
  assign b_ld    = b;
  assign acc_fin = acc_shift;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
    neg_d     = neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mcand_d = a_ld;
          acc_d   = {{WIDTH{1'b0}}, b_ld};
          cnt_d   = CW'(WIDTH - 1);
          state_d = S_CALC;
`ifdef SEQ_MULT_SIGNED_EN
          neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
`endif
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          acc_d   = acc_fin;
          state_d = S_DONE;
        end else begin
          acc_d = acc_shift;
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign product = acc_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl: WIDTH=8 and WIDTH=4 instances against a cycle-level reference model.
// Signed expectations apply when SEQ_MULT_SIGNED_EN is defined.
module tb_seq_mult_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  logic       iv[2];
  logic       orr[2];
  logic [7:0] av[2];
  logic [7:0] bv[2];
  logic       ir[2];
  logic       ov[2];
  logic       bz[2];
  logic [15:0] pr[2];

  logic        ir8, ov8, bz8;
  logic [15:0] p8;
  logic        ir4, ov4, bz4;
  logic [7:0]  p4;
  logic [3:0]  a4, b4;

  assign a4 = av[1][3:0];
  assign b4 = bv[1][3:0];

  seq_mult_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir8), .a(av[0]), .b(bv[0]),
    .out_valid(ov8), .out_ready(orr[0]), .product(p8), .busy(bz8)
  );

  seq_mult_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(orr[1]), .product(p4), .busy(bz4)
  );

  assign ir[0] = ir8;  assign ov[0] = ov8;  assign bz[0] = bz8;  assign pr[0] = p8;
  assign ir[1] = ir4;  assign ov[1] = ov4;  assign bz[1] = bz4;  assign pr[1] = {8'h00, p4};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    $display("FAIL %s: actual=no response required=response within bound", nm);
  endtask

  // Exact product from plain integer arithmetic, truncated to 2*w bits.
  function automatic logic [15:0] ref_mul(input int w, input logic [7:0] x, input logic [7:0] y);
    longint m, sx, sy, p;
    m  = (longint'(1) << w) - 1;
    sx = longint'(x) & m;
    sy = longint'(y) & m;
`ifdef SEQ_MULT_SIGNED_EN
    if (sx >= (longint'(1) << (w - 1))) sx -= longint'(1) << w;
    if (sy >= (longint'(1) << (w - 1))) sy -= longint'(1) << w;
`endif
    p = (sx * sy) & ((longint'(1) << (2 * w)) - 1);
    return p[15:0];
  endfunction

  // Reference model: an accepted pair makes out_valid due WIDTH edges after the accept edge,
  // held until out_ready; product keeps its last value while idle.
  bit          busy_m[2];
  int          tacc[2];
  logic [15:0] exp_m[2];
  logic [15:0] prod_m[2];

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int d = 0; d < 2; d++) begin
          busy_m[d] = 1'b0;
          prod_m[d] = '0;
        end
      end else begin
        for (int d = 0; d < 2; d++) begin
          int   w;
          logic ov_e;
          w    = (d == 0) ? 8 : 4;
          ov_e = busy_m[d] && (cyc >= tacc[d] + w);
          chk(d ? "w4 in_ready" : "w8 in_ready", ir[d], !busy_m[d]);
          chk(d ? "w4 out_valid" : "w8 out_valid", ov[d], ov_e);
          chk(d ? "w4 busy" : "w8 busy", bz[d], busy_m[d]);
          if (ov_e) chk(d ? "w4 product" : "w8 product", pr[d], exp_m[d]);
          else if (!busy_m[d]) chk(d ? "w4 product idle" : "w8 product idle", pr[d], prod_m[d]);
          if (!busy_m[d] && iv[d]) begin
            busy_m[d] = 1'b1;
            tacc[d]   = cyc + 1;
            exp_m[d]  = ref_mul(w, av[d], bv[d]);
          end else if (ov_e && orr[d]) begin
            busy_m[d] = 1'b0;
            prod_m[d] = exp_m[d];
          end
        end
      end
    end
  end

  // One transaction; called at 1 time unit after a rising edge, returns at the same phase.
  task automatic op(input int d, input logic [7:0] x, input logic [7:0] y, input int stall,
                    input bit noise, output logic [15:0] got, output int lat, output int irlow);
    int g, t0;
    got = '0; lat = -1; irlow = 0;
    av[d] = x; bv[d] = y; iv[d] = 1'b1; orr[d] = 1'b0;
    g = 0;
    while (!ir[d] && g < 200) begin @(posedge clk); #1; g++; end
    if (g >= 200) begin tmo("in_ready wait"); iv[d] = 1'b0; return; end
    @(posedge clk); #1;
    t0 = cyc; iv[d] = 1'b0;
    g = 0;
    while (!ov[d] && g < 200) begin
      if (!ir[d]) irlow++;
      if (noise) begin
        iv[d] = 1'($urandom_range(0, 1)); av[d] = 8'($urandom); bv[d] = 8'($urandom);
        orr[d] = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1; g++;
    end
    if (g >= 200) begin tmo("out_valid wait"); iv[d] = 1'b0; orr[d] = 1'b0; return; end
    lat = cyc - t0;
    repeat (stall) begin
      if (!ir[d]) irlow++;
      orr[d] = 1'b0;
      if (noise) begin iv[d] = 1'($urandom_range(0, 1)); av[d] = 8'($urandom); bv[d] = 8'($urandom); end
      @(posedge clk); #1;
    end
    if (!ir[d]) irlow++;
    got = pr[d]; orr[d] = 1'b1; iv[d] = 1'b0;
    @(posedge clk); #1;
    orr[d] = 1'b0;
  endtask

  task automatic sweep(input int d, input int n);
    logic [15:0] g;
    int l, il, w;
    w = (d == 0) ? 8 : 4;
    for (int i = 0; i < n; i++) begin
      op(d, 8'($urandom), 8'($urandom), $urandom_range(0, 3), 1'b1, g, l, il);
      chk(d ? "w4 accept-to-valid" : "w8 accept-to-valid", l, w);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  typedef struct { logic [7:0] x; logic [7:0] y; logic [15:0] p; } vec_t;
  vec_t vecs[8];

  initial begin
    logic [15:0] got;
    int lat, irl;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin iv[d] = 0; orr[d] = 0; av[d] = 0; bv[d] = 0; end
    vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{8'h00, 8'hA5, 16'h0000};
    vecs[2] = '{8'h80, 8'h02, 16'h0100};
    vecs[3] = '{8'h03, 8'h04, 16'h000C};
    vecs[4] = '{8'h80, 8'h80, 16'h4000};
`ifdef SEQ_MULT_SIGNED_EN
    vecs[0].p = 16'h0001;
    vecs[2].p = 16'hFF00;
    vecs[5] = '{8'hFD, 8'h05, 16'hFFF1};
    vecs[6] = '{8'h7F, 8'hFF, 16'hFF81};
`else
    vecs[5] = '{8'hFD, 8'h05, 16'h04F1};
    vecs[6] = '{8'h7F, 8'hFF, 16'h7E81};
`endif
    vecs[7] = '{8'h37, 8'h2B, 16'h093D};

    #2;
    chk("reset in_ready", ir8, 1'b1);
    chk("reset out_valid", ov8, 1'b0);
    chk("reset busy", bz8, 1'b0);
    chk("reset product", p8, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    op(0, 8'd13, 8'd11, 0, 1'b0, got, lat, irl);
    chk("13x11 product", got, 16'd143);
    chk("13x11 edges accept-to-valid", lat, 8);
    chk("13x11 in_ready low cycles", irl, 9);

    for (int i = 0; i < 7; i++) begin
      op(0, vecs[i].x, vecs[i].y, $urandom_range(0, 2), 1'b0, got, lat, irl);
      chk($sformatf("vec%0d product", i), got, vecs[i].p);
    end

    // Back-pressure: five stalled DONE cycles with operand noise on the input side.
    op(0, vecs[7].x, vecs[7].y, 5, 1'b1, got, lat, irl);
    chk("stall product", got, vecs[7].p);
    chk("stall in_ready low cycles", irl, 14);

    // Abort three cycles into CALC.
    av[0] = 8'h5A; bv[0] = 8'hC3; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre-abort busy", bz8, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort out_valid", ov8, 1'b0);
    chk("abort busy", bz8, 1'b0);
    chk("abort product", p8, 16'h0000);
    chk("abort in_ready", ir8, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    op(0, 8'd3, 8'd4, 0, 1'b0, got, lat, irl);
    chk("post-abort 3x4", got, 16'd12);

    fork
      sweep(0, 1000);
      sweep(1, 1000);
    join

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
